bus_arb2: RTL and testbench

BUS_ARB2 -- requirements
Module: bus_arb2

---
 rtl/bus_arb2.sv | 148 ++++++++++++++
 tb/tb_bus_arb2.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// Two-master round-robin bus arbiter in front of a single slave port.
// Define ARB_TIMEOUT_EN to add the slave-response watchdog with err/err_code outputs.
module bus_arb2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_hrd,
    output logic        m1_hrd,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m0_spo,
    output logic [31:0] m1_spo,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic        s_req,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
`ifdef ARB_TIMEOUT_EN
    output logic        err,
    output logic [15:0] err_code,
`endif
    input  logic        s_gnt,
    input  logic        s_hrd,
    input  logic [31:0] s_spo,
    input  logic        s_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last, last_nx;
    logic   busy, busy_nx;
    logic   owner;
    logic   timeout;
    logic   done;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("bus_arb2: TIMEOUT must lie in 1..255");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            busy  <= busy_nx;
        end
    end

    // Only the current owner's address, data and strobes ever reach the slave.
    always_comb begin
        s_a  = '0;
        s_d  = '0;
        s_we = 1'b0;
        s_rd = 1'b0;
        case (state)
            OWN0: begin
                s_a  = m0_a;
                s_d  = m0_d;
                s_we = m0_we;
                s_rd = m0_rd;
            end
            OWN1: begin
                s_a  = m1_a;
                s_d  = m1_d;
                s_we = m1_we;
                s_rd = m1_rd;
            end
            default: ;
        endcase
    end

    assign owner    = (state == OWN1);
    assign done     = s_ready | timeout;
    assign s_req    = (state != IDLE);
    assign m0_gnt   = (state == OWN0) & s_gnt;
    assign m1_gnt   = (state == OWN1) & s_gnt;
    assign m0_hrd   = (state == OWN1) | ((state == OWN0) & s_hrd);
    assign m1_hrd   = (state == OWN0) | ((state == OWN1) & s_hrd);
    assign m0_spo   = s_spo;
    assign m1_spo   = s_spo;
    assign m0_ready = done & (state == OWN0);
    assign m1_ready = done & (state == OWN1);

    // An owner that has let go of its request keeps the bus until its transfer completes;
    // the handoff then happens on the completing edge itself.
    always_comb begin
        state_nx = state;
        last_nx  = last;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) state_nx = last ? OWN0 : OWN1;
                else if (m0_req)      state_nx = OWN0;
                else if (m1_req)      state_nx = OWN1;
            end
            OWN0: begin
                if (!m0_req && (!busy || done)) state_nx = m1_req ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!m1_req && (!busy || done)) state_nx = m0_req ? OWN0 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == OWN0)      last_nx = 1'b0;
        else if (state_nx == OWN1) last_nx = 1'b1;
        if (done)                          busy_nx = 1'b0;
        else if ((s_we | s_rd) && s_gnt)   busy_nx = 1'b1;
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Counter holds the number of busy cycles already elapsed, so the watchdog fires
    // on the TIMEOUT-th busy cycle and behaves as a forced completion.
    always_ff @(posedge clk) begin
        if (!rst_n) wd_cnt <= 8'd0;
        else        wd_cnt <= busy ? wd_cnt + 8'd1 : 8'd0;
    end

    assign timeout  = busy && (wd_cnt == 8'(TIMEOUT - 1));
    assign err      = timeout;
    assign err_code = timeout ? {15'b0, owner} : 16'h0000;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arb2.sv
// Randomized self-checking bench for bus_arb2 against a behavioural arbitration model.
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT = 4).
module tb_bus_arb2;

    localparam int TB_TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, rd;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [1:0]  gnt, hrd, ready;
    logic [31:0] spo0, spo1;
    logic        s_req, s_we, s_rd;
    logic [31:0] s_a, s_d;
    logic        s_gnt, s_hrd, s_ready;
    logic [31:0] s_spo;
`ifdef ARB_TIMEOUT_EN
    logic        err;
    logic [15:0] err_code;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: owner (-1 = nobody), most recent owner, pending transfer, busy cycles elapsed.
    int mo_owner, mo_last, mo_age;
    bit mo_busy;
    int nx_owner, nx_last, nx_age;
    bit nx_busy;

    bus_arb2 #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_gnt(gnt[0]), .m1_gnt(gnt[1]),
        .m0_hrd(hrd[0]), .m1_hrd(hrd[1]),
        .m0_a(a[0]), .m0_d(d[0]), .m1_a(a[1]), .m1_d(d[1]),
        .m0_we(we[0]), .m0_rd(rd[0]), .m1_we(we[1]), .m1_rd(rd[1]),
        .m0_spo(spo0), .m1_spo(spo1),
        .m0_ready(ready[0]), .m1_ready(ready[1]),
        .s_req(s_req), .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
`ifdef ARB_TIMEOUT_EN
        .err(err), .err_code(err_code),
`endif
        .s_gnt(s_gnt), .s_hrd(s_hrd), .s_spo(s_spo), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Compare every output with the model, then work out the model's state after the next edge.
    task automatic checkOutput();
        int o;
        bit to;
        logic [31:0] exp_a, exp_d;
        logic exp_we, exp_rd;
        o  = mo_owner;
        to = TO_EN && mo_busy && (mo_age + 1 == TB_TIMEOUT);
        exp_a  = (o == 0) ? a[0]  : (o == 1) ? a[1]  : 32'h0;
        exp_d  = (o == 0) ? d[0]  : (o == 1) ? d[1]  : 32'h0;
        exp_we = (o == 0) ? we[0] : (o == 1) ? we[1] : 1'b0;
        exp_rd = (o == 0) ? rd[0] : (o == 1) ? rd[1] : 1'b0;
        cmp("s_req", {31'b0, s_req}, {31'b0, o >= 0});
        cmp("s_a", s_a, exp_a);
        cmp("s_d", s_d, exp_d);
        cmp("s_we", {31'b0, s_we}, {31'b0, exp_we});
        cmp("s_rd", {31'b0, s_rd}, {31'b0, exp_rd});
        for (int x = 0; x < 2; x++) begin
            cmp("gnt", {31'b0, gnt[x]}, {31'b0, (o == x) && s_gnt});
            cmp("hrd", {31'b0, hrd[x]}, {31'b0, (o == 1 - x) || ((o == x) && s_hrd)});
            cmp("ready", {31'b0, ready[x]}, {31'b0, (o == x) && (s_ready || to)});
        end
        if (!to) begin
            cmp("m0_spo", spo0, s_spo);
            cmp("m1_spo", spo1, s_spo);
        end
`ifdef ARB_TIMEOUT_EN
        cmp("err", {31'b0, err}, {31'b0, to});
        cmp("err_code", {16'b0, err_code}, to ? 32'(o) : 32'h0);
`endif
        nx_owner = o;
        if (o < 0) begin
            if (req == 2'b11)  nx_owner = 1 - mo_last;
            else if (req[0])   nx_owner = 0;
            else if (req[1])   nx_owner = 1;
        end else if (!req[o] && (!mo_busy || s_ready || to)) begin
            nx_owner = req[1 - o] ? 1 - o : -1;
        end
        nx_last = (nx_owner >= 0) ? nx_owner : mo_last;
        if (s_ready || to)                                 nx_busy = 1'b0;
        else if (o >= 0 && (we[o] || rd[o]) && s_gnt)      nx_busy = 1'b1;
        else                                               nx_busy = mo_busy;
        nx_age = mo_busy ? mo_age + 1 : 0;
        if (!rst_n) begin
            nx_owner = -1;
            nx_last  = 1;
            nx_busy  = 1'b0;
            nx_age   = 0;
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        mo_owner = nx_owner;
        mo_last  = nx_last;
        mo_busy  = nx_busy;
        mo_age   = nx_age;
        #1;
    endtask

    task automatic applyStimulus();
        rst_n = ($urandom_range(99) != 0);
        for (int i = 0; i < 2; i++) begin
            if ($urandom_range(9) < 3) req[i] = ~req[i];
            we[i] = ($urandom_range(3) == 0);
            rd[i] = ($urandom_range(3) == 0);
            a[i]  = $urandom;
            d[i]  = $urandom;
        end
        s_gnt   = ($urandom_range(7) != 0);
        s_hrd   = ($urandom_range(4) == 0);
        s_ready = ($urandom_range(9) < 3);
        s_spo   = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00; rd = 2'b00;
        a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;
        s_gnt = 1'b1; s_hrd = 1'b0; s_ready = 1'b0; s_spo = 32'hA5A5_0001;
        mo_owner = -1; mo_last = 1; mo_busy = 1'b0; mo_age = 0;
        @(posedge clk);
        #1;
        runCycle();
        cmp("rst_s_req", {31'b0, s_req}, 32'd0);
        cmp("rst_gnt", {30'b0, gnt}, 32'd0);
        cmp("rst_s_we", {31'b0, s_we}, 32'd0);
        cmp("rst_s_rd", {31'b0, s_rd}, 32'd0);

        // Single requester after reset.
        rst_n = 1'b1; req = 2'b01;
        #1;
        cmp("idle_no_gnt", {31'b0, gnt[0]}, 32'd0);
        runCycle();
        cmp("first_gnt0", {31'b0, gnt[0]}, 32'd1);
        cmp("first_s_req", {31'b0, s_req}, 32'd1);
        cmp("first_hrd0", {31'b0, hrd[0]}, 32'd0);

        // Round-robin handoffs.
        req = 2'b11;
        runCycle();
        cmp("hold_gnt0", {31'b0, gnt[0]}, 32'd1);
        cmp("m1_held", {31'b0, hrd[1]}, 32'd1);
        req = 2'b10;
        runCycle();
        cmp("handoff_gnt1", {31'b0, gnt[1]}, 32'd1);
        req = 2'b00;
        runCycle();
        req = 2'b11;
        runCycle();
        cmp("rr_gnt0", {31'b0, gnt[0]}, 32'd1);

        // Owner drops request mid-read; bus stays until s_ready.
        rd[0] = 1'b1; a[0] = 32'h8000_0010;
        #1;
        cmp("rd_s_a", s_a, 32'h8000_0010);
        cmp("rd_s_rd", {31'b0, s_rd}, 32'd1);
        runCycle();
        req = 2'b10; rd[0] = 1'b0;
        runCycle();
        cmp("busy_keeps_gnt0", {31'b0, gnt[0]}, 32'd1);
        s_ready = 1'b1;
        #1;
        cmp("ready0", {31'b0, ready[0]}, 32'd1);
        cmp("ready1", {31'b0, ready[1]}, 32'd0);
        runCycle();
        s_ready = 1'b0;
        #1;
        cmp("after_ready_gnt1", {31'b0, gnt[1]}, 32'd1);

        // Non-owner strobes never reach the slave.
        we[0] = 1'b1; a[0] = 32'h0000_1234; a[1] = 32'h0000_5555;
        #1;
        cmp("nonowner_we", {31'b0, s_we}, 32'd0);
        cmp("owner_addr", s_a, 32'h0000_5555);
        cmp("nonowner_hrd", {31'b0, hrd[0]}, 32'd1);
        we[0] = 1'b0;

        // Reset while busy abandons the transfer.
        rd[1] = 1'b1;
        runCycle();
        rd[1] = 1'b0; rst_n = 1'b0;
        runCycle();
        cmp("rst_busy_s_req", {31'b0, s_req}, 32'd0);
        cmp("rst_busy_ready", {30'b0, ready}, 32'd0);
        rst_n = 1'b1; req = 2'b00;
        runCycle();

`ifdef ARB_TIMEOUT_EN
        // Watchdog fires on the 4th cycle after the strobe.
        req = 2'b10;
        runCycle();
        rd[1] = 1'b1;
        runCycle();
        rd[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp("err_early", {31'b0, err}, 32'd0);
            runCycle();
        end
        cmp("err_pulse", {31'b0, err}, 32'd1);
        cmp("err_code", {16'b0, err_code}, 32'h0001);
        cmp("to_ready1", {31'b0, ready[1]}, 32'd1);
        req = 2'b00;
        runCycle();
`endif

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
